// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data memory responder: word RAM plus MMIO timer and TX byte FIFO
//
// Purpose:
//    Answers the core's data memory port. Addresses whose top nibble equals
//    MMIO_NIB hit the MMIO window (cycle timer with compare interrupt, TX
//    byte FIFO with a valid/ready console output); everything else hits a
//    word-addressed RAM. Read data is combinational from ram_addr so the
//    MEM stage can consume it in the same cycle.
//
// Ports:
//    clk        in   1   clock, all state updates on the rising edge
//    reset      in   1   synchronous, active-low reset
//    ram_addr   in  32   byte address from the core
//    ram_wdata  in  32   store data from the core
//    ram_we     in   1   write strobe, one access per cycle
//    ram_rdata  out 32   read data, combinational from ram_addr
//    tx_data    out  8   FIFO head byte (0 while empty)
//    tx_valid   out  1   FIFO non-empty
//    tx_ready   in   1   sink accepts the head byte
//    timer_irq  out  1   timer pending & enable
//    bus_err    out  1   sticky access error
//
// Configuration:
//    DMEM_BOUNDS_CHK_EN - when defined, misaligned accesses and RAM accesses
//    beyond the implemented range set the sticky bus_err, suppress the write
//    and read as 0. When undefined, addresses alias and bus_err is tied to 0.
//
// MMIO map (offset ram_addr[7:0]):
//    0x00 MTIME     RW   free-running cycle counter
//    0x04 MTIMECMP  RW   compare value
//    0x08 CTRL      bit0 enable (RW), bit1 pending (R, W1C)
//    0x0C TX_DATA   WO   push ram_wdata[7:0]
//    0x10 STATUS    bit0 empty, bit1 full, bit2 overflow (W1C), [FIFO_AW+4:4] count

module dmem_responder #(
   parameter int unsigned RAM_AW   = 10,
   parameter int unsigned FIFO_AW  = 2,
   parameter logic [3:0]  MMIO_NIB = 4'h8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ram_addr,
   input  logic [31:0] ram_wdata,
   input  logic        ram_we,
   output logic [31:0] ram_rdata,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        timer_irq,
   output logic        bus_err
);

   localparam int unsigned RAM_WORDS  = 1 << RAM_AW;
   localparam int unsigned FIFO_DEPTH = 1 << FIFO_AW;

   localparam logic [7:0] OFF_MTIME    = 8'h00;
   localparam logic [7:0] OFF_MTIMECMP = 8'h04;
   localparam logic [7:0] OFF_CTRL     = 8'h08;
   localparam logic [7:0] OFF_TX_DATA  = 8'h0C;
   localparam logic [7:0] OFF_STATUS   = 8'h10;

   // count value meaning "every slot occupied"
   localparam logic [FIFO_AW:0] FIFO_FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

   // ---------------------------------------------------------------
   // Address decode
   // ---------------------------------------------------------------
   logic              is_mmio;
   logic              is_ram;
   logic [7:0]        mmio_off;
   logic [RAM_AW-1:0] ram_idx;
   logic              acc_err;

   assign is_mmio  = (ram_addr[31:28] == MMIO_NIB);
   assign is_ram   = ~is_mmio;
   assign mmio_off = ram_addr[7:0];
   assign ram_idx  = ram_addr[RAM_AW+1:2];

   // Address bits that only matter to the optional bounds check; they are
   // ignored (aliased) otherwise.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{ram_addr[27:RAM_AW+2], ram_addr[1:0]};

`ifdef DMEM_BOUNDS_CHK_EN
   always_comb begin
      acc_err = (ram_addr[1:0] != 2'b00);
      if (is_ram && (ram_addr[27:RAM_AW+2] != '0)) begin
         acc_err = 1'b1;
      end
   end
`else
   assign acc_err = 1'b0;
`endif

   // An erroring access never modifies state.
   logic wr_ok;
   logic ram_wr;
   logic mmio_wr;

   assign wr_ok   = ram_we & ~acc_err;
   assign ram_wr  = wr_ok & is_ram;
   assign mmio_wr = wr_ok & is_mmio;

   // ---------------------------------------------------------------
   // Data RAM: synchronous write, asynchronous read. A read of the word
   // being written returns the old contents until the edge.
   // ---------------------------------------------------------------
   logic [31:0] ram_q [RAM_WORDS];

   always_ff @(posedge clk) begin
      if (ram_wr) begin
         ram_q[ram_idx] <= ram_wdata;
      end
   end

   // ---------------------------------------------------------------
   // Timer
   // ---------------------------------------------------------------
   logic [31:0] mtime_q, mtime_d;
   logic [31:0] mtimecmp_q, mtimecmp_d;
   logic        enable_q, enable_d;
   logic        pending_q, pending_d;

   always_comb begin
      mtime_d    = mtime_q + 32'd1;
      mtimecmp_d = mtimecmp_q;
      enable_d   = enable_q;
      pending_d  = pending_q;

      if (mmio_wr && (mmio_off == OFF_MTIME)) begin
         mtime_d = ram_wdata;           // load replaces this cycle's increment
      end
      if (mmio_wr && (mmio_off == OFF_MTIMECMP)) begin
         mtimecmp_d = ram_wdata;
      end
      if (mmio_wr && (mmio_off == OFF_CTRL)) begin
         enable_d = ram_wdata[0];
         if (ram_wdata[1]) begin
            pending_d = 1'b0;
         end
      end
      // Evaluated last so a match wins over a same-cycle W1C clear.
      if (mtime_q == mtimecmp_q) begin
         pending_d = 1'b1;
      end
   end

   assign timer_irq = pending_q & enable_q;

   // ---------------------------------------------------------------
   // TX FIFO
   // ---------------------------------------------------------------
   logic [7:0]         fifo_q [FIFO_DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]   count_q, count_d;
   logic               overflow_q, overflow_d;
   logic               fifo_empty;
   logic               fifo_full;
   logic               push_req;
   logic               push;
   logic               pop;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == FIFO_FULL_CNT);
   assign push_req   = mmio_wr && (mmio_off == OFF_TX_DATA);
   // A pop while empty is meaningless and is simply not performed.
   assign pop        = ~fifo_empty & tx_ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push       = push_req & (~fifo_full | pop);

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + (FIFO_AW+1)'(1);
         2'b01:   count_d = count_q - (FIFO_AW+1)'(1);
         default: count_d = count_q;
      endcase

      if (mmio_wr && (mmio_off == OFF_STATUS) && ram_wdata[2]) begin
         overflow_d = 1'b0;
      end
      if (push_req && !push) begin
         overflow_d = 1'b1;
      end
   end

   // Storage is not reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_q[wr_ptr_q] <= ram_wdata[7:0];
      end
   end

   assign tx_valid = ~fifo_empty;
   // Forced to 0 while empty so stale storage never reaches the pins.
   assign tx_data  = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q];

   // ---------------------------------------------------------------
   // Sticky access error
   // ---------------------------------------------------------------
`ifdef DMEM_BOUNDS_CHK_EN
   logic bus_err_q, bus_err_d;

   assign bus_err_d = bus_err_q | acc_err;

   always_ff @(posedge clk) begin
      if (!reset) begin
         bus_err_q <= 1'b0;
      end else begin
         bus_err_q <= bus_err_d;
      end
   end

   assign bus_err = bus_err_q;
`else
   assign bus_err = 1'b0;
`endif

   // ---------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         mtime_q    <= 32'h0000_0000;
         mtimecmp_q <= 32'hFFFF_FFFF;
         enable_q   <= 1'b0;
         pending_q  <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         enable_q   <= enable_d;
         pending_q  <= pending_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // ---------------------------------------------------------------
   // Read data mux
   // ---------------------------------------------------------------
   logic [31:0] status_word;

   always_comb begin
      status_word              = 32'h0;
      status_word[0]           = fifo_empty;
      status_word[1]           = fifo_full;
      status_word[2]           = overflow_q;
      status_word[FIFO_AW+4:4] = count_q;
   end

   always_comb begin
      ram_rdata = 32'h0;
      if (acc_err) begin
         ram_rdata = 32'h0;
      end else if (is_ram) begin
         ram_rdata = ram_q[ram_idx];
      end else begin
         case (mmio_off)
            OFF_MTIME:    ram_rdata = mtime_q;
            OFF_MTIMECMP: ram_rdata = mtimecmp_q;
            OFF_CTRL:     ram_rdata = {30'h0, pending_q, enable_q};
            OFF_STATUS:   ram_rdata = status_word;
            default:      ram_rdata = 32'h0;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
module tb_dmem_responder;

   localparam logic [31:0] A_MTIME    = 32'h8000_0000;
   localparam logic [31:0] A_MTIMECMP = 32'h8000_0004;
   localparam logic [31:0] A_CTRL     = 32'h8000_0008;
   localparam logic [31:0] A_TX       = 32'h8000_000C;
   localparam logic [31:0] A_STATUS   = 32'h8000_0010;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] ram_addr = 32'h0;
   logic [31:0] ram_wdata = 32'h0;
   logic        ram_we = 1'b0;
   logic [31:0] ram_rdata;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic        timer_irq;
   logic        bus_err;

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] exp_q[$];

   dmem_responder dut (
      .clk       (clk),
      .reset     (reset),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_we    (ram_we),
      .ram_rdata (ram_rdata),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .timer_irq (timer_irq),
      .bus_err   (bus_err)
   );

   always #5 clk = ~clk;

   // All stimulus changes at 1 time unit after a rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      ram_addr  = a;
      ram_wdata = d;
      ram_we    = 1'b1;
      step();
      ram_we    = 1'b0;
      ram_addr  = 32'h0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      ram_addr = a;
      ram_we   = 1'b0;
      #1;
      d = ram_rdata;
      ram_addr = 32'h0;
   endtask

   task automatic push_byte(input logic [7:0] b);
      bus_write(A_TX, {24'h0, b});
      exp_q.push_back(b);
   endtask

   // Drain the FIFO through the scoreboard; bounded so a stuck tx_valid cannot hang.
   task automatic drain(input int n_exp);
      int popped = 0;
      logic [7:0] e;
      tx_ready = 1'b1;
      #1;
      for (int k = 0; k < 16; k++) begin
         if (!tx_valid) break;
         if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL drain_extra: got byte %h with empty scoreboard", tx_data);
         end else begin
            e = exp_q.pop_front();
            n_checks++;
            if (tx_data !== e) begin
               n_fail++;
               $display("FAIL drain_byte%0d: got %h expected %h", popped, tx_data, e);
            end
         end
         popped++;
         step();
      end
      tx_ready = 1'b0;
      n_checks++;
      if (popped != n_exp || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain_count: got %0d popped (%0d left) expected %0d", popped, exp_q.size(), n_exp);
      end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      reset = 1'b0;
      step();
      step();
      n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tx_valid: got %b expected 0", tx_valid); end
      n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_tx_data: got %h expected 00", tx_data); end
      n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b expected 0", timer_irq); end
      n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL rst_bus_err: got %b expected 0", bus_err); end
      bus_read(A_MTIME, d);
      n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_mtime: got %h expected 0", d); end
      bus_read(A_MTIMECMP, d);
      n_checks++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rst_mtimecmp: got %h expected ffffffff", d); end
      bus_read(A_CTRL, d);
      n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_ctrl: got %h expected 0", d); end
      bus_read(A_STATUS, d);
      n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL rst_status: got %h expected 1", d); end
      reset = 1'b1;
      step();
   endtask

   task automatic test_ram();
      logic [31:0] d;
      bus_write(32'h0000_0010, 32'hDEAD_BEEF);
      bus_read(32'h0000_0010, d);
      n_checks++; if (d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_rd: got %h expected deadbeef", d); end
      ram_addr = 32'h0000_0010; ram_wdata = 32'h1234_5678; ram_we = 1'b1;
      #1;
      n_checks++; if (ram_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_rdw_old: got %h expected deadbeef", ram_rdata); end
      step();
      ram_we = 1'b0;
      #1;
      n_checks++; if (ram_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL ram_rdw_new: got %h expected 12345678", ram_rdata); end
`ifndef DMEM_BOUNDS_CHK_EN
      bus_read(32'h0000_1010, d);
      n_checks++; if (d !== 32'h1234_5678) begin n_fail++; $display("FAIL ram_alias: got %h expected 12345678", d); end
`endif
      ram_addr = 32'h0;
   endtask

   task automatic test_mtime_wrap();
      logic [31:0] d;
      bus_write(A_MTIME, 32'hFFFF_FFFE);
      bus_read(A_MTIME, d);
      n_checks++; if (d !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mtime_load: got %h expected fffffffe", d); end
      step();
      bus_read(A_MTIME, d);
      n_checks++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mtime_max: got %h expected ffffffff", d); end
      step();
      bus_read(A_MTIME, d);
      n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL mtime_wrap: got %h expected 0", d); end
   endtask

   task automatic test_timer();
      logic [31:0] d;
      logic [31:0] m;
      logic        exp_pend;
      bus_write(A_MTIME, 32'd100);
      bus_write(A_MTIMECMP, 32'd105);
      bus_write(A_CTRL, 32'h3);      // enable, clear pending left over from the wrap test
      m = 32'd102;
      exp_pend = 1'b0;
      n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL irq_armed: got %b expected 0", timer_irq); end
      for (int k = 0; k < 7; k++) begin
         step();
         if (m == 32'd105) exp_pend = 1'b1;
         m = m + 32'd1;
         n_checks++;
         if (timer_irq !== exp_pend) begin
            n_fail++;
            $display("FAIL irq_cycle%0d: got %b expected %b", k, timer_irq, exp_pend);
         end
      end
      bus_read(A_CTRL, d);
      n_checks++; if (d !== 32'h3) begin n_fail++; $display("FAIL ctrl_pending: got %h expected 3", d); end
      bus_write(A_CTRL, 32'h3);
      n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL irq_cleared: got %b expected 0", timer_irq); end
      bus_read(A_CTRL, d);
      n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL ctrl_after_clr: got %h expected 1", d); end
   endtask

   task automatic test_fifo_overflow();
      logic [31:0] d;
      tx_ready = 1'b0;
      push_byte(8'h41);
      n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin n_fail++; $display("FAIL fifo_first_head: got v=%b d=%h expected v=1 d=41", tx_valid, tx_data); end
      push_byte(8'h42);
      push_byte(8'h43);
      push_byte(8'h44);
      bus_read(A_STATUS, d);
      n_checks++; if (d !== 32'h42) begin n_fail++; $display("FAIL fifo_full_status: got %h expected 42", d); end
      bus_write(A_TX, 32'h45);        // dropped, not in scoreboard
      bus_read(A_STATUS, d);
      n_checks++; if (d !== 32'h46) begin n_fail++; $display("FAIL fifo_overflow_status: got %h expected 46", d); end
      n_checks++; if (tx_data !== 8'h41) begin n_fail++; $display("FAIL fifo_head_stall: got %h expected 41", tx_data); end
      bus_write(A_STATUS, 32'h4);
      bus_read(A_STATUS, d);
      n_checks++; if (d !== 32'h42) begin n_fail++; $display("FAIL fifo_ovf_clear: got %h expected 42", d); end
      drain(4);
      bus_read(A_STATUS, d);
      n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL fifo_empty_status: got %h expected 1", d); end
   endtask

   task automatic test_full_push_pop();
      logic [31:0] d;
      logic [7:0]  e;
      for (int i = 0; i < 4; i++) push_byte(8'h60 + 8'(i));
      ram_addr = A_TX; ram_wdata = 32'h55; ram_we = 1'b1; tx_ready = 1'b1;
      #1;
      e = exp_q.pop_front();
      n_checks++; if (tx_valid !== 1'b1 || tx_data !== e) begin n_fail++; $display("FAIL full_pop_head: got v=%b d=%h expected v=1 d=%h", tx_valid, tx_data, e); end
      exp_q.push_back(8'h55);
      step();
      ram_we = 1'b0; tx_ready = 1'b0;
      bus_read(A_STATUS, d);
      n_checks++; if (d !== 32'h42) begin n_fail++; $display("FAIL full_pushpop_status: got %h expected 42", d); end
      drain(4);
   endtask

   task automatic test_empty_push_pop();
      tx_ready = 1'b1;
      ram_addr = A_TX; ram_wdata = 32'h77; ram_we = 1'b1;
      #1;
      n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL empty_pop_valid: got %b expected 0", tx_valid); end
      exp_q.push_back(8'h77);
      step();
      ram_we = 1'b0; ram_addr = 32'h0;
      drain(1);
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      tx_ready = 1'b0;
      push_byte(8'h11);
      push_byte(8'h22);
      tx_ready = 1'b1;
      reset = 1'b0;
      step();
      n_checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_tx: got v=%b d=%h expected v=0 d=00", tx_valid, tx_data); end
      reset = 1'b1;
      tx_ready = 1'b0;
      exp_q.delete();
      step();
      bus_read(A_STATUS, d);
      n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL rstmid_status: got %h expected 1", d); end
   endtask

   task automatic test_bus_err();
      logic [31:0] d;
      bus_write(32'h0000_0000, 32'h1111_2222);
      bus_write(32'h0000_0002, 32'hBAD0_BAD0);
      bus_read(32'h0000_0000, d);
`ifdef DMEM_BOUNDS_CHK_EN
      n_checks++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL berr_set: got %b expected 1", bus_err); end
      n_checks++; if (d !== 32'h1111_2222) begin n_fail++; $display("FAIL berr_ram_kept: got %h expected 11112222", d); end
      step();
      step();
      n_checks++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL berr_sticky: got %b expected 1", bus_err); end
      reset = 1'b0;
      step();
      reset = 1'b1;
      n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL berr_reset: got %b expected 0", bus_err); end
`else
      n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL berr_tied: got %b expected 0", bus_err); end
      n_checks++; if (d !== 32'hBAD0_BAD0) begin n_fail++; $display("FAIL berr_alias_write: got %h expected bad0bad0", d); end
`endif
   endtask

   initial begin
      test_reset();
      test_ram();
      test_mtime_wrap();
      test_timer();
      test_fifo_overflow();
      test_full_push_pop();
      test_empty_push_pop();
      test_reset_mid();
      test_bus_err();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-side responder for the core's data memory port (ram_addr / ram_wdata / ram_we in, ram_rdata out).
- Serves a word-addressed data RAM, plus an MMIO window containing a cycle timer with compare interrupt and a byte TX FIFO with a valid/ready console output.
- Sits at SoC level between the core and peripheral pins.
- Read data is combinational so the MEM stage consumes it in the same cycle.

Parameters:
RAM_AW, 10, RAM word-address width (2^RAM_AW 32-bit words)
FIFO_AW, 2, TX FIFO depth = 2^FIFO_AW entries
MMIO_NIB, 4'h8, value of ram_addr[31:28] that selects the MMIO window

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-low reset
ram_addr  input  32  byte address from core
ram_wdata  input  32  store data from core
ram_we  input  1  write strobe, one access per cycle
ram_rdata  output  32  read data, combinational from ram_addr
tx_data  output  8  FIFO head byte
tx_valid  output  1  FIFO non-empty
tx_ready  input  1  sink accepts head byte
timer_irq  output  1  pending & enable
bus_err  output  1  sticky access error (0 unless DMEM_BOUNDS_CHK_EN)

Behaviour:
- Reset (reset==0 at clk edge):
  - mtime=0, mtimecmp=32'hFFFF_FFFF, enable=0, pending=0.
  - FIFO pointers and count=0, overflow=0, bus_err=0.
  - Outputs: tx_valid=0, timer_irq=0, tx_data=0.
  - RAM contents are not reset.
- Decode:
  - MMIO when ram_addr[31:28]==MMIO_NIB; otherwise RAM.
  - RAM index = ram_addr[RAM_AW+1:2]; upper and low two bits are ignored (aliasing).
- RAM:
  - Write is a full word on the edge when ram_we=1.
  - Read is asynchronous.
  - Read and write to the same address in the same cycle returns the old word; the new word is visible the next cycle.
- MMIO map (offset ram_addr[7:0]):
  - 0x00 MTIME, RW. Increments every cycle and wraps 32'hFFFF_FFFF -> 0. A write loads ram_wdata and suppresses that cycle's increment.
  - 0x04 MTIMECMP, RW.
  - 0x08 CTRL. Bit0 = enable (RW). Bit1 = pending: read; writing 1 clears it.
  - 0x0C TX_DATA, WO. A write pushes ram_wdata[7:0]. Reads return 0.
  - 0x10 STATUS, RO except bit2.
    - bit0 empty, bit1 full, bit2 overflow (writing 1 clears it).
    - bits[FIFO_AW+4:4] count (range 0..2^FIFO_AW); remaining bits read 0.
  - Other offsets read 0; writes are ignored.
- Timer:
  - pending is set on the edge where mtime==mtimecmp, then held sticky.
  - If set and W1C clear occur in the same cycle, set wins.
  - timer_irq is registered-state combinational: pending & enable.
- TX FIFO:
  - Push on a TX_DATA write; pop when tx_valid & tx_ready.
  - A pushed byte is at the head and tx_valid=1 on the cycle after the write.
  - tx_data holds the head byte and is stable while tx_valid & !tx_ready.
  - Push while full without a same-cycle pop: byte dropped, overflow=1, count unchanged.
  - Push while full with a same-cycle pop: push accepted, count unchanged.
  - Push and pop while empty: pop is ignored (tx_valid=0), push is accepted.
  - Pointers wrap modulo 2^FIFO_AW.
- Reset asserted mid-transfer:
  - FIFO is emptied and tx_valid drops the next edge.
  - Any in-flight handshake is abandoned; no partial byte is popped.

Optional Feature:
- Macro DMEM_BOUNDS_CHK_EN.
- Defined: a RAM-region access sets bus_err (sticky until reset) when either
  - ram_addr[1:0]!=0, or
  - ram_addr[27:RAM_AW+2]!=0 (out of range).
  Effect of an erroring access: the write is suppressed and ram_rdata=0. MMIO accesses with ram_addr[1:0]!=0 also set bus_err and are ignored.
- Undefined: no checks, aliasing as above, and bus_err is tied to 0.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x0000_0010 and read 0x0000_0010 -> ram_rdata=0xDEADBEEF next cycle. Same-cycle read during write to 0x0000_0010 -> previous word.
- Write MTIME=0xFFFF_FFFE -> reads 0xFFFF_FFFF one cycle later, then 0x0000_0000 one cycle after that (wrap).
- Write MTIMECMP=mtime+5 and CTRL=1 -> timer_irq=1 from the 5th edge onward. Write CTRL=0x3 -> pending cleared, timer_irq=0.
- Push 0x41,0x42,0x43,0x44 with tx_ready=0 -> STATUS full=1, count=4. Push 0x45 -> overflow=1 and 0x45 is lost. Raise tx_ready -> bytes 0x41..0x44 are popped one per cycle, then tx_valid=0.
- FIFO full, push 0x55 while popping the head -> push accepted, count stays 4, and 0x55 emerges last.
- With DMEM_BOUNDS_CHK_EN defined, write to 0x0000_0002 -> bus_err=1 and RAM unchanged; bus_err remains 1 until reset is driven low.
